// File: rtl/column_hole_filler_if.sv
// Stream interface for column_hole_filler: sample input, filled-sample output, frame markers and stats.
// master = sample producer/consumer side, slave = the filler itself.
interface column_hole_filler_if #(
    parameter int data_width = 21,
    parameter int fc_width   = 16
);
    logic [data_width-1:0] in_data;
    logic                  in_valid;
    logic [data_width-1:0] out_data;
    logic                  out_valid;
    logic                  out_col_start;
    logic                  out_frame_start;
    logic                  frame_done;
    logic [2:0]            frame_index;
    logic [fc_width-1:0]   fill_count;

    modport master (
        output in_data, in_valid,
        input  out_data, out_valid, out_col_start, out_frame_start, frame_done, frame_index, fill_count
    );

    modport slave (
        input  in_data, in_valid,
        output out_data, out_valid, out_col_start, out_frame_start, frame_done, frame_index, fill_count
    );
endinterface

// File: rtl/column_hole_filler.sv
// Fills zero-disparity holes in a column-major stream with the last good sample of the same column.
// Optional per-frame fill statistics are enabled by defining COLUMN_HOLE_FILLER_FILL_STATS_EN.
module column_hole_filler #(
    parameter int width      = 120,
    parameter int height     = 240,
    parameter int data_width = 21,
    parameter int disp_width = 8,
    parameter int max_fill   = 16,
    parameter int tag_len    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    column_hole_filler_if.slave    bus
);
    localparam int row_w   = (height > 1) ? $clog2(height) : 1;
    localparam int col_w   = (width > 1) ? $clog2(width) : 1;
    localparam int run_w   = (max_fill > 0) ? $clog2(max_fill + 1) : 1;
    localparam int fc_w    = $clog2(width * height) + 1;
    localparam int tag_eff = (tag_len > height) ? height : tag_len;
    localparam logic [row_w:0]   tag_lim  = (row_w + 1)'(tag_eff);
    localparam logic [row_w-1:0] row_last = row_w'(height - 1);
    localparam logic [col_w-1:0] col_last = col_w'(width - 1);
    localparam logic [run_w-1:0] run_max  = run_w'(max_fill);

    logic [row_w-1:0]      row_q, row_d;
    logic [col_w-1:0]      col_q, col_d;
    logic [data_width-1:0] last_good_q, last_good_d;
    logic                  have_last_q, have_last_d;
    logic [run_w-1:0]      run_q, run_d;

    logic                  out_valid_q, out_col_start_q, out_frame_start_q, frame_done_q;
    logic [data_width-1:0] out_data_q;
    logic [2:0]            frame_index_q;

    logic                  row0_s, col0_s, is_tag_s, hole_s, fill_s, frame_last_s;
    logic                  have_s;
    logic [run_w-1:0]      run_s;
    logic [data_width-1:0] last_s, data_d;

    // Row/column position of the incoming sample.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (bus.in_valid) begin
            if (row_q == row_last) begin
                row_d = '0;
                if (col_q == col_last) begin
                    col_d = '0;
                end else begin
                    col_d = col_q + col_w'(1);
                end
            end else begin
                row_d = row_q + row_w'(1);
            end
        end else begin
            row_d = row_q;
        end
    end

    // Hole classification and per-column fill state; state is seen as cleared on row 0.
    always_comb begin
        row0_s       = (row_q == '0);
        col0_s       = (col_q == '0);
        frame_last_s = (row_q == row_last) && (col_q == col_last);
        is_tag_s     = col0_s && ({1'b0, row_q} < tag_lim);
        hole_s       = (bus.in_data[disp_width-1:0] == '0);
        have_s       = row0_s ? 1'b0 : have_last_q;
        run_s        = row0_s ? '0 : run_q;
        last_s       = row0_s ? '0 : last_good_q;
        have_last_d  = have_s;
        run_d        = run_s;
        last_good_d  = last_s;
        fill_s       = 1'b0;
        if (is_tag_s) begin
            fill_s = 1'b0;
        end else if (!hole_s) begin
            last_good_d = bus.in_data;
            have_last_d = 1'b1;
            run_d       = '0;
        end else if (have_s && (run_s < run_max)) begin
            fill_s = 1'b1;
            run_d  = run_s + run_w'(1);
        end else begin
            fill_s = 1'b0;
        end
        data_d = fill_s ? last_s : bus.in_data;
    end

    // Position counters and column fill state, advanced only by valid samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q       <= '0;
            col_q       <= '0;
            last_good_q <= '0;
            have_last_q <= 1'b0;
            run_q       <= '0;
        end else if (bus.in_valid) begin
            row_q       <= row_d;
            col_q       <= col_d;
            last_good_q <= last_good_d;
            have_last_q <= have_last_d;
            run_q       <= run_d;
        end
    end

    // Registered output stage: one cycle behind the input, markers only with valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q       <= 1'b0;
            out_col_start_q   <= 1'b0;
            out_frame_start_q <= 1'b0;
            frame_done_q      <= 1'b0;
            out_data_q        <= '0;
            frame_index_q     <= 3'd0;
        end else begin
            out_valid_q       <= bus.in_valid;
            out_col_start_q   <= bus.in_valid & row0_s;
            out_frame_start_q <= bus.in_valid & row0_s & col0_s;
            frame_done_q      <= bus.in_valid & frame_last_s;
            if (bus.in_valid) begin
                out_data_q <= data_d;
            end
            if (bus.in_valid && is_tag_s && row0_s) begin
                frame_index_q <= bus.in_data[2:0];
            end
        end
    end

`ifdef COLUMN_HOLE_FILLER_FILL_STATS_EN
    logic [fc_w-1:0] fill_cnt_q;
    logic [fc_w-1:0] fill_count_q;

    // Running fill count; the total (including the last sample) is published at frame end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_cnt_q   <= '0;
            fill_count_q <= '0;
        end else if (bus.in_valid) begin
            if (frame_last_s) begin
                fill_count_q <= fill_cnt_q + fc_w'(fill_s);
                fill_cnt_q   <= '0;
            end else begin
                fill_cnt_q   <= fill_cnt_q + fc_w'(fill_s);
            end
        end
    end

    assign bus.fill_count = fill_count_q;
`else
    assign bus.fill_count = '0;
`endif

    assign bus.out_valid       = out_valid_q;
    assign bus.out_col_start   = out_col_start_q;
    assign bus.out_frame_start = out_frame_start_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.out_data        = out_data_q;
    assign bus.frame_index     = frame_index_q;
endmodule

// File: tb/tb_column_hole_filler.sv
// Scoreboard bench for column_hole_filler on a 4x8 frame (tag_len=2, max_fill=2) with
// hand-computed expected outputs per sample.
module tb_column_hole_filler;
    localparam int W   = 4;
    localparam int H   = 8;
    localparam int DW  = 21;
    localparam int FCW = $clog2(W * H) + 1;
`ifdef COLUMN_HOLE_FILLER_FILL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0]  data;
        logic           cs;
        logic           fs;
        logic           fd;
        logic [2:0]     fi;
        logic [FCW-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    column_hole_filler_if #(.data_width(DW), .fc_width(FCW)) bus_if ();

    column_hole_filler #(
        .width(W), .height(H), .data_width(DW), .disp_width(8), .max_fill(2), .tag_len(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_if)
    );

    exp_t           q[$];
    exp_t           m_e;
    int             checks = 0;
    int             errors = 0;
    logic [2:0]     exp_fi = 3'd0;
    logic [FCW-1:0] exp_fc = '0;
    logic [DW-1:0]  fa_in[32];
    logic [DW-1:0]  fa_out[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {31'd0, bus_if.out_valid}, 32'd0);
        check({tag, "_markers"}, {29'd0, bus_if.out_col_start, bus_if.out_frame_start, bus_if.frame_done}, 32'd0);
        check({tag, "_out_data"}, {11'd0, bus_if.out_data}, 32'd0);
        check({tag, "_frame_index"}, {29'd0, bus_if.frame_index}, 32'd0);
        check({tag, "_fill_count"}, {26'd0, bus_if.fill_count}, 32'd0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a sample.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus_if.out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    m_e = q.pop_front();
                    check("out_data", {11'd0, bus_if.out_data}, {11'd0, m_e.data});
                    check("col_start", {31'd0, bus_if.out_col_start}, {31'd0, m_e.cs});
                    check("frame_start", {31'd0, bus_if.out_frame_start}, {31'd0, m_e.fs});
                    check("frame_done", {31'd0, bus_if.frame_done}, {31'd0, m_e.fd});
                    check("frame_index", {29'd0, bus_if.frame_index}, {29'd0, m_e.fi});
                    check("fill_count", {26'd0, bus_if.fill_count}, {26'd0, m_e.fc});
                end
            end else begin
                check("idle_markers", {29'd0, bus_if.out_col_start, bus_if.out_frame_start, bus_if.frame_done}, 32'd0);
            end
        end
    end

    // alt replaces column 3 by a constant non-hole column (no fills there).
    task automatic run_frame(input logic [DW-1:0] tag, input bit alt, input bit gaps, input int stop_at);
        for (int i = 0; i < 32; i++) begin
            logic [DW-1:0] d;
            logic [DW-1:0] o;
            exp_t          e;
            if (i == stop_at) break;
            d = (i == 0) ? tag : ((alt && i >= 24) ? 21'h000011 : fa_in[i]);
            o = (i == 0) ? tag : ((alt && i >= 24) ? 21'h000011 : fa_out[i]);
            if (i == 0) exp_fi = tag[2:0];
            if (i == 31) exp_fc = STATS ? (alt ? FCW'(9) : FCW'(12)) : '0;
            @(negedge clk);
            bus_if.in_data  = d;
            bus_if.in_valid = 1'b1;
            e.data = o;
            e.cs   = (i % 8 == 0);
            e.fs   = (i == 0);
            e.fd   = (i == 31);
            e.fi   = exp_fi;
            e.fc   = exp_fc;
            q.push_back(e);
            if (gaps) begin
                repeat (i % 3) begin
                    @(negedge clk);
                    bus_if.in_valid = 1'b0;
                    bus_if.in_data  = 21'h000000;
                end
            end
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // column-major, row fastest; index 0 is replaced by the frame tag
        fa_in  = '{21'h0, 21'h0, 21'h7, 21'h0, 21'h0, 21'h9, 21'h0, 21'h0,
                   21'h3, 21'h0, 21'h0, 21'h0, 21'h0, 21'h4, 21'h8, 21'h6,
                   21'h0, 21'h300, 21'h2, 21'h500, 21'h0, 21'h0, 21'h1234, 21'h0,
                   21'h11, 21'h0, 21'h22, 21'h33, 21'h0, 21'h0, 21'h0, 21'h44};
        fa_out = '{21'h0, 21'h0, 21'h7, 21'h7, 21'h7, 21'h9, 21'h9, 21'h9,
                   21'h3, 21'h3, 21'h3, 21'h0, 21'h0, 21'h4, 21'h8, 21'h6,
                   21'h0, 21'h300, 21'h2, 21'h2, 21'h2, 21'h0, 21'h1234, 21'h1234,
                   21'h11, 21'h11, 21'h22, 21'h33, 21'h33, 21'h33, 21'h0, 21'h44};
        bus_if.in_data  = 21'h000000;
        bus_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;

        run_frame(21'h000005, 1'b0, 1'b0, 32);
        run_frame(21'h1ABCDB, 1'b1, 1'b1, 32);

        // abandon a frame after 13 samples
        run_frame(21'h000006, 1'b0, 1'b0, 13);
        repeat (2) @(negedge clk);
        check("pre_reset_drain", q.size(), 32'd0);
        reset_n         = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 21'h000033;
        @(negedge clk);
        check_reset_outputs("mid_rst1");
        @(negedge clk);
        check_reset_outputs("mid_rst2");
        bus_if.in_valid = 1'b0;
        exp_fi  = 3'd0;
        exp_fc  = '0;
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        run_frame(21'h000002, 1'b0, 1'b0, 32);

        for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
        check("final_drain", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/column_hole_filler.md
COLUMN_HOLE_FILLER -- requirements
Module: column_hole_filler

Interface
REQ-001 Parameter width, default 120, columns per frame.
REQ-002 Parameter height, default 240, rows per column.
REQ-003 Parameter data_width, default 21, sample word width.
REQ-004 Parameter disp_width, default 8, disparity field = in_data[disp_width-1:0].
REQ-005 Parameter max_fill, default 16, longest hole run filled per run.
REQ-006 Parameter tag_len, default 32, frame-tag samples at start of each frame.
REQ-007 Port clk  input  1  sole clock, all state on rising edge.
REQ-008 Port reset_n  input  1  asynchronous, active-low reset.
REQ-009 Port in_data  input  data_width  column-major sample stream (row fastest).
REQ-010 Port in_valid  input  1  in_data qualifier, any duty cycle incl. back-to-back.
REQ-011 Port out_data  output  data_width  filled sample.
REQ-012 Port out_valid  output  1  out_data qualifier.
REQ-013 Port out_col_start  output  1  high with out_valid on row 0 of every column.
REQ-014 Port out_frame_start  output  1  high with out_valid on row 0 of column 0.
REQ-015 Port frame_done  output  1  high with out_valid on last sample (col width-1, row height-1).
REQ-016 Port frame_index  output  3  frame tag latched from current frame.
REQ-017 Port fill_count  output  $clog2(width*height)+1  filled-sample count of last completed frame.

Function
REQ-018 Latency SHALL be exactly 1 cycle: out_valid(t+1)=in_valid(t), no gaps or reordering; no backpressure.
REQ-019 Counters row (0..height-1) and col (0..width-1) SHALL advance only on in_valid; row wraps to 0 and col increments; after (width-1,height-1) both return to 0.
REQ-020 Sample is a tag when col==0 and row<tag_len; tags SHALL pass unmodified and never update fill state.
REQ-021 On tag at row 0, frame_index SHALL load in_data[2:0] in the same cycle out_data appears.
REQ-022 Non-tag sample is a hole when disparity field == 0.
REQ-023 Per column state: last_good (data_width), have_last (1), run (saturating at max_fill); cleared at row 0 of every column.
REQ-024 Non-hole: out_data=in_data, last_good<=in_data, have_last<=1, run<=0.
REQ-025 Hole with have_last==1 and run<max_fill: out_data=last_good, run<=run+1, counted as filled.
REQ-026 Hole otherwise (no predecessor in column, or run==max_fill): out_data=in_data unchanged, run saturates; no further fill until next non-hole.
REQ-027 Fill SHALL never cross a column boundary: row-0 hole always passes unfilled.
REQ-028 Markers out_col_start/out_frame_start/frame_done SHALL be single-cycle, aligned with out_valid, zero otherwise.

Reset
REQ-029 While reset_n low: out_valid, out_col_start, out_frame_start, frame_done, out_data, frame_index, fill_count, row, col, run, have_last, last_good all 0.
REQ-030 Reset mid-frame SHALL abandon the frame; first in_valid after release is treated as col 0 row 0 (tag) of a new frame.

Configuration
REQ-031 Macro COLUMN_HOLE_FILLER_FILL_STATS_EN defined: internal counter increments per filled sample; on frame_done cycle fill_count loads final total (incl. that sample) and internal counter clears.
REQ-032 Macro undefined: counter logic absent, fill_count tied to 0; all other behaviour identical.

Verification
REQ-033 width=4,height=8,tag_len=2; frame tag word 5 at row 0 -> frame_index=5 one cycle later, out_frame_start=1, tag passes unmodified.
REQ-034 Column disparities 7,0,0,9 (rows 2..5) -> outputs 7,7,7,9; fill_count +2 (macro on).
REQ-035 max_fill=2, column 3,0,0,0,0 -> outputs 3,3,3,0,0; run saturates.
REQ-036 Column 1 ends in 6, column 2 row 0 disparity 0 -> output 0, out_col_start=1 (no cross-column fill).
REQ-037 Back-to-back in_valid for full 4x8 frame -> 32 out_valid, frame_done on 32nd only, counters at 0 after.
REQ-038 reset_n low at sample 13, released, new frame streamed -> all outputs 0 during reset, next sample treated as tag row 0, fill_count unchanged until new frame_done.
